prog_loader: RTL and testbench

Byte-stream program loader that writes the instruction memory read by the CPU core and gates the core's `cpu_en`. It sits between a UART byte receiver and the instruction-memory write port. It holds the core disabled while a framed program image is received, writes each assembled 32-bit word to consecutive text addresses, and releases `cpu_en` once the image is complete and valid.

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: assembles a framed byte stream into big-endian 32-bit instruction-memory writes and holds cpu_en low until the image is complete.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to the frame.
module prog_loader #(
  parameter logic [31:0] TEXT_BASE_ADDR = 32'h0040_0000,
  parameter int          MAX_WORDS      = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_en,
  output logic        busy,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = S_CHK;
`else
  localparam logic [2:0] S_DONE   = 3'd5;
`endif
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [7:0]  MAGIC   = 8'hA5;
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  logic [2:0]  state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  byte_cnt;
  logic [23:0] word_sh;
  logic [7:0]  csum;
  logic [15:0] n_rx;
  logic        len_bad;
  logic        last_word;

  assign n_rx      = {len_hi, rx_data};
  assign len_bad   = (n_rx == 16'd0) || ({1'b0, n_rx} > MAX_LEN);
  assign last_word = (idx == len - 16'd1);

  // Status outputs decode the registered state, so they change one cycle after the deciding byte.
  assign cpu_en = (state == S_RUN);
  assign err    = (state == S_ERR);
`ifdef LOADER_CHECKSUM_EN
  assign busy   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA) || (state == S_CHK);
`else
  assign busy   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      len_hi       <= 8'd0;
      len          <= 16'd0;
      idx          <= 16'd0;
      byte_cnt     <= 2'd0;
      word_sh      <= 24'd0;
      csum         <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= TEXT_BASE_ADDR;
      imem_wdata   <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == MAGIC) state <= S_LEN_HI;
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            len_hi <= rx_data;
            csum   <= rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_valid) begin
            len          <= n_rx;
            idx          <= 16'd0;
            byte_cnt     <= 2'd0;
            words_loaded <= 16'd0;
            csum         <= csum ^ rx_data;
            state        <= len_bad ? S_ERR : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            word_sh  <= {word_sh[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            csum     <= csum ^ rx_data;
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= TEXT_BASE_ADDR + {14'd0, idx, 2'b00};
              imem_wdata   <= {word_sh, rx_data};
              idx          <= idx + 16'd1;
              words_loaded <= words_loaded + 16'd1;
              if (last_word) state <= (S_DONE == S_RUN) ? S_RUN : S_DONE;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) state <= (rx_data == csum) ? S_RUN : S_ERR;
        end
`endif
        S_RUN: begin
          if (load_req) state <= S_IDLE;
        end
        S_ERR: begin
          // A reload request wins over a simultaneous magic byte.
          if (load_req) state <= S_IDLE;
          else if (rx_valid && rx_data == MAGIC) state <= S_LEN_HI;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames plus hand-written reload, error, reset and spacing sequences; writes checked against a scoreboard.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          MAXW = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        load_req = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_en;
  logic        busy;
  logic        err;
  logic [15:0] words_loaded;

  prog_loader #(.TEXT_BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .load_req(load_req),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_en(cpu_en),
    .busy(busy), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [31:0] cyc; } obs_t;
  typedef struct {
    logic [7:0]        hi;
    logic [7:0]        lo;
    int                nw;
    logic [3:0][31:0]  w;
    bit                bad_cs;
    bit                gap;
  } vec_t;

  exp_t        exp_q[$];
  obs_t        obs[$];
  int          obs_rd = 0;
  logic [31:0] cyc = 32'd0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (imem_we) obs.push_back({imem_addr, imem_wdata, cyc});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input int nw,
                            input logic [3:0][31:0] w, input bit bad_cs, input bit gap);
    logic [7:0]  cs;
    logic [15:0] n;
    bit          legal;
    n     = {hi, lo};
    legal = (n != 16'd0) && (int'(n) <= MAXW);
    send_byte(8'hA5, gap);
    send_byte(hi, gap);
    send_byte(lo, gap);
    cs = hi ^ lo;
    if (legal) begin
      for (int i = 0; i < nw; i++) begin
        exp_q.push_back({BASE + 32'(4 * i), w[i]});
        for (int b = 3; b >= 0; b--) begin
          if (!CSUM_EN && i == nw - 1 && b == 0) chk("cpu_en_early", {31'd0, cpu_en}, 32'd0);
          cs = cs ^ w[i][8*b +: 8];
          send_byte(w[i][8*b +: 8], gap);
        end
      end
      if (CSUM_EN) begin
        chk("cpu_en_early", {31'd0, cpu_en}, 32'd0);
        send_byte(bad_cs ? (cs ^ 8'h01) : cs, gap);
      end
    end
  endtask

  task automatic drain();
    int n_new;
    n_new = obs.size() - obs_rd;
    chk("wr_count", n_new, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_new; i++) begin
      chk("wr_addr", obs[obs_rd + i].addr, exp_q[i].addr);
      chk("wr_data", obs[obs_rd + i].data, exp_q[i].data);
    end
    obs_rd = obs.size();
    exp_q.delete();
  endtask

  task automatic reload();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("cpu_en_drop", {31'd0, cpu_en}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  function automatic vec_t mk(logic [7:0] hi, logic [7:0] lo, int nw, logic [31:0] w0, logic [31:0] w1,
                              logic [31:0] w2, logic [31:0] w3, bit bad_cs, bit gap);
    vec_t v;
    v.hi = hi; v.lo = lo; v.nw = nw;
    v.w = {w3, w2, w1, w0};
    v.bad_cs = bad_cs; v.gap = gap;
    return v;
  endfunction

  vec_t vt[8];

  initial begin
    bit               legal;
    bit               exp_run;
    int               start;
    logic [7:0]       cs;
    logic [3:0][31:0] basic;
    basic = {32'h0, 32'h0, 32'h0000_000C, 32'h2408_0005};

    vt[0] = mk(8'h00, 8'h02, 2, 32'h2408_0005, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 1'b0);
    vt[1] = mk(8'h00, 8'h02, 2, 32'h2408_0005, 32'h0000_000C, 32'h0, 32'h0, 1'b1, 1'b0);
    vt[2] = mk(8'h00, 8'h01, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    vt[3] = mk(8'h00, 8'h00, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vt[4] = mk(8'h00, 8'h05, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vt[5] = mk(8'h01, 8'h00, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    vt[6] = mk(8'h00, 8'h04, 4, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 1'b0, 1'b0);
    vt[7] = mk(8'h00, 8'h03, 3, 32'hA5A5_A5A5, 32'h00A5_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);

    // Reset state, both during and just after reset.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_imem_addr", imem_addr, BASE);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_words", {16'd0, words_loaded}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
    end

    for (int v = 0; v < 8; v++) begin
      legal   = ({vt[v].hi, vt[v].lo} != 16'd0) && (int'({vt[v].hi, vt[v].lo}) <= MAXW);
      exp_run = legal && !(CSUM_EN && vt[v].bad_cs);
      send_frame(vt[v].hi, vt[v].lo, vt[v].nw, vt[v].w, vt[v].bad_cs, vt[v].gap);
      chk($sformatf("v%0d_cpu_en", v), {31'd0, cpu_en}, {31'd0, exp_run});
      chk($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, !exp_run});
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_words", v), {16'd0, words_loaded}, legal ? 32'(vt[v].nw) : 32'd0);
      @(negedge clk);
      drain();
      if (exp_run) reload();
    end

    // Reload from RUN with a stray byte before the next frame.
    send_frame(8'h00, 8'h02, 2, basic, 1'b0, 1'b0);
    chk("rl_run", {31'd0, cpu_en}, 32'd1);
    @(negedge clk);
    drain();
    reload();
    send_byte(8'h11, 1'b0);
    chk("rl_stray_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h00, 8'h01, 1, {96'd0, 32'h1357_2468}, 1'b0, 1'b0);
    chk("rl_run2", {31'd0, cpu_en}, 32'd1);
    chk("rl_words", {16'd0, words_loaded}, 32'd1);
    @(negedge clk);
    drain();
    reload();

    // ERR exits: magic byte restarts a frame, load_req returns to IDLE.
    send_frame(8'h00, 8'h00, 0, 128'd0, 1'b0, 1'b0);
    chk("err_set", {31'd0, err}, 32'd1);
    send_byte(8'hA5, 1'b0);
    chk("err_clr_magic", {31'd0, err}, 32'd0);
    chk("err_busy_magic", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h09, 1'b0);
    chk("err_set2", {31'd0, err}, 32'd1);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("err_clr_req", {31'd0, err}, 32'd0);
    chk("err_req_busy", {31'd0, busy}, 32'd0);

    // load_req held through the header and first data bytes must not abort the frame.
    send_byte(8'hA5, 1'b0);
    load_req = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    chk("lr_mid_busy", {31'd0, busy}, 32'd1);
    load_req = 1'b0;
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    cs = 8'h00 ^ 8'h01 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
    if (CSUM_EN) send_byte(cs, 1'b0);
    exp_q.push_back({BASE, 32'hDEAD_BEEF});
    chk("lr_run", {31'd0, cpu_en}, 32'd1);
    @(negedge clk);
    drain();
    reload();

    // Back-to-back 3-word frame: write strobes exactly 4 cycles apart.
    start = obs.size();
    send_frame(8'h00, 8'h03, 3, {32'h0, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001}, 1'b0, 1'b0);
    @(negedge clk);
    if (obs.size() - start == 3) begin
      chk("b2b_gap01", obs[start + 1].cyc - obs[start].cyc, 32'd4);
      chk("b2b_gap12", obs[start + 2].cyc - obs[start + 1].cyc, 32'd4);
    end
    drain();
    reload();

    // Reset after 6 bytes: outputs return to reset values at once, remaining bytes ignored.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
    chk("mid_rst_addr", imem_addr, BASE);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_words", {16'd0, words_loaded}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_byte(8'h05, 1'b0);
    send_byte(8'h0C, 1'b0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    drain();
    send_frame(8'h00, 8'h02, 2, basic, 1'b0, 1'b0);
    chk("post_rst_run", {31'd0, cpu_en}, 32'd1);
    chk("post_rst_words", {16'd0, words_loaded}, 32'd2);
    @(negedge clk);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
